// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two pipeline requesters, the shared
// single-port memory and mem_arbiter.
//   Fetch requester : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   Data requester  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   Memory          : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   Status          : busy
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// requester and the data requester, one transaction outstanding at a time.
// Each transaction walks IDLE (grant) -> ACCESS (memory strobe) -> WAIT
// (MEM_LAT cycles, read data captured on the last) -> RESP (rvalid pulse).
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus_io - mem_arbiter_if.slave: requester handshakes, memory bus, busy
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (memory read latency, legal 1..4).
//
// Optional feature macro ARB_FAIR_EN: when defined, contention between the
// two requesters is resolved round-robin (the one not granted last wins);
// when undefined, data always beats fetch and no pointer register exists.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic          clk_i,
    input logic          rst_i,
    mem_arbiter_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    localparam logic [2:0] CntLoad = 3'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = data requester, 0 = fetch
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_FAIR_EN
    logic              last_d_q, last_d_d;  // 1 = data was granted last
`endif

    logic              pick_d, pick_if;
    logic              if_gnt, d_gnt, if_rvalid, d_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Winner selection among the currently pending requests.
    always_comb begin
        pick_d  = 1'b0;
        pick_if = 1'b0;
        if (bus_io.d_req && bus_io.if_req) begin
`ifdef ARB_FAIR_EN
            pick_d  = ~last_d_q;
            pick_if = last_d_q;
`else
            pick_d  = 1'b1;
`endif
        end else begin
            pick_d  = bus_io.d_req;
            pick_if = bus_io.if_req;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_FAIR_EN
        last_d_d   = last_d_q;
`endif
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            StIdle: begin
                // No grant while reset is asserted: the access would be lost.
                if (!rst_i && (pick_d || pick_if)) begin
                    d_gnt   = pick_d;
                    if_gnt  = pick_if;
                    owner_d = pick_d;
                    we_d    = pick_d & bus_io.d_we;  // fetch is read-only
                    addr_d  = pick_d ? bus_io.d_addr : bus_io.if_addr;
                    wdata_d = pick_d ? bus_io.d_wdata : '0;
`ifdef ARB_FAIR_EN
                    last_d_d = pick_d;
`endif
                    state_d = StAccess;
                end
            end
            StAccess: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                cnt_d     = CntLoad;
                state_d   = StWait;
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = bus_io.mem_rdata;
                        end else begin
                            if_rdata_d = bus_io.mem_rdata;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                // A reset landing here discards the transaction, so no pulse.
                d_rvalid  = ~rst_i & owner_q;
                if_rvalid = ~rst_i & ~owner_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 3'd0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_FAIR_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_FAIR_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    assign bus_io.if_gnt    = if_gnt;
    assign bus_io.d_gnt     = d_gnt;
    assign bus_io.if_rvalid = if_rvalid;
    assign bus_io.d_rvalid  = d_rvalid;
    assign bus_io.if_rdata  = if_rdata_q;
    assign bus_io.d_rdata   = d_rdata_q;
    assign bus_io.mem_en    = mem_en;
    assign bus_io.mem_we    = mem_we;
    assign bus_io.mem_addr  = mem_addr;
    assign bus_io.mem_wdata = mem_wdata;
    assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LAT=1 instance checked every cycle against a
// transaction-timeline model, plus a MEM_LAT=3 instance for latency checks.
module tb_mem_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 1;
    localparam int unsigned LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst3, mem_init;
    int   n_assert = 0;
    int   n_fail   = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus1)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst3),
        .bus_io(bus3)
    );

    function automatic logic [31:0] init_word(input int unsigned a);
        if (a == 16) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory environment (data valid exactly LAT cycles on) ----------------
    logic [31:0] env_mem1 [64];
    logic [31:0] env_mem3 [64];
    logic [31:0] pipe1 [LAT];
    logic [31:0] pipe3 [LAT3];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) env_mem1[i] <= init_word(i);
        end else if (bus1.mem_en && bus1.mem_we) begin
            env_mem1[bus1.mem_addr[5:0]] <= bus1.mem_wdata;
        end
        pipe1[0] <= (bus1.mem_en && !bus1.mem_we) ? env_mem1[bus1.mem_addr[5:0]] : $urandom;
    end
    assign bus1.mem_rdata = pipe1[LAT-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) env_mem3[i] <= init_word(i);
        end else if (bus3.mem_en && bus3.mem_we) begin
            env_mem3[bus3.mem_addr[5:0]] <= bus3.mem_wdata;
        end
        pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? env_mem3[bus3.mem_addr[5:0]] : $urandom;
        for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
    end
    assign bus3.mem_rdata = pipe3[LAT3-1];

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction timeline: grant at offset 0, access at 1, rvalid at LAT+2.
    logic        m_on = 1'b0;
    logic        m_act, m_own, m_we, m_ptr;
    int unsigned m_k;
    logic [31:0] m_addr, m_wd, e_if_rd, e_d_rd;
    logic [31:0] ref_mem [64];

    always @(negedge clk) begin
        logic win_d, win_i, exp_en;
        if (mem_init) for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        win_d = 1'b0;
        win_i = 1'b0;
        if (m_on && !m_act && !rst) begin
            if (bus1.d_req && bus1.if_req) begin
`ifdef ARB_FAIR_EN
                win_d = ~m_ptr;
                win_i = m_ptr;
`else
                win_d = 1'b1;
`endif
            end else begin
                win_d = bus1.d_req;
                win_i = bus1.if_req;
            end
        end
        if (m_on) begin
            exp_en = m_act && (m_k == 1);
            chk("gnt", {bus1.if_gnt, bus1.d_gnt}, {win_i, win_d});
            chk("busy", 128'(bus1.busy), 128'(m_act));
            chk("rvalid", {bus1.if_rvalid, bus1.d_rvalid},
                {m_act && m_k == LAT + 2 && !m_own && !rst,
                 m_act && m_k == LAT + 2 && m_own && !rst});
            chk("mem_bus", {bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata},
                {exp_en, exp_en && m_we, exp_en ? m_addr : 32'h0, exp_en ? m_wd : 32'h0});
            chk("rdata", {bus1.if_rdata, bus1.d_rdata}, {e_if_rd, e_d_rd});
        end
        if (rst) begin
            m_on    = 1'b1;
            m_act   = 1'b0;
            m_ptr   = 1'b0;
            m_k     = 0;
            e_if_rd = 32'h0;
            e_d_rd  = 32'h0;
        end else if (m_on && !m_act) begin
            if (win_d || win_i) begin
                m_act  = 1'b1;
                m_k    = 1;
                m_own  = win_d;
                m_we   = win_d && bus1.d_we;
                m_addr = win_d ? bus1.d_addr : bus1.if_addr;
                m_wd   = win_d ? bus1.d_wdata : 32'h0;
                m_ptr  = win_d;
                if (m_we) ref_mem[m_addr[5:0]] = m_wd;
            end
        end else if (m_on) begin
            if (m_k == LAT + 1 && !m_we) begin
                if (m_own) e_d_rd = ref_mem[m_addr[5:0]];
                else e_if_rd = ref_mem[m_addr[5:0]];
            end
            if (m_k == LAT + 2) m_act = 1'b0;
            else m_k++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        logic       ig_prev, dg_prev;
        logic [3:0] seq;
        int         ncyc [4];
        int         ng, gi, gd;
        logic [3:0] exp_seq;

        rst = 1'b1; rst3 = 1'b1; mem_init = 1'b1;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0;
        bus3.if_req = 0; bus3.if_addr = 0; bus3.d_req = 0; bus3.d_we = 0;
        bus3.d_addr = 0; bus3.d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst3 = 1'b0; mem_init = 1'b0;

        // Reset state
        neg();
        chk("reset_state", {bus1.busy, bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid,
            bus1.d_rvalid, bus1.mem_en, bus1.mem_we}, 128'h0);
        chk("reset_rdata", {bus1.if_rdata, bus1.d_rdata}, 128'h0);
        chk("reset_mem", {bus1.mem_addr, bus1.mem_wdata}, 128'h0);
        chk("reset_state3", {bus3.busy, bus3.d_rvalid, bus3.mem_en, bus3.d_rdata}, 128'h0);

        // Fetch of 0x10
        tick(); bus1.if_req = 1; bus1.if_addr = 32'h10;
        neg();  chk("fetch_gnt", {bus1.if_gnt, bus1.d_gnt}, 2'b10);
        tick(); bus1.if_req = 0;
        neg();  chk("fetch_access", {bus1.mem_en, bus1.mem_we, bus1.mem_addr},
                    {1'b1, 1'b0, 32'h10});
        tick(); tick();
        neg();  chk("fetch_rvalid", {bus1.if_rvalid, bus1.if_rdata}, {1'b1, 32'hDEADBEEF});

        // Data write then read-back
        tick(); bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'h20; bus1.d_wdata = 32'h12345678;
        neg();  chk("write_gnt", {bus1.if_gnt, bus1.d_gnt}, 2'b01);
        tick(); bus1.d_req = 0; bus1.d_we = 0;
        neg();  chk("write_access", {bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata},
                    {1'b1, 1'b1, 32'h20, 32'h12345678});
        tick(); tick();
        neg();  chk("write_ack", {bus1.d_rvalid, bus1.d_rdata}, {1'b1, 32'h0});
        tick(); bus1.d_req = 1; bus1.d_addr = 32'h20;
        neg();  chk("read_gnt", {bus1.if_gnt, bus1.d_gnt}, 2'b01);
        tick(); bus1.d_req = 0;
        tick(); tick();
        neg();  chk("read_data", {bus1.d_rvalid, bus1.d_rdata}, {1'b1, 32'h12345678});

        // Contention: each side keeps requesting until it has two grants
        seq = 0; ng = 0; gi = 0; gd = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            bus1.if_req = (gi < 2); bus1.if_addr = 32'h4;
            bus1.d_req = (gd < 2); bus1.d_we = 0; bus1.d_addr = 32'h8;
            neg();
            if (bus1.if_gnt || bus1.d_gnt) begin
                seq[ng] = bus1.d_gnt;
                ncyc[ng] = c;
                ng++;
                if (bus1.d_gnt) gd++;
                else gi++;
            end
        end
        tick(); bus1.if_req = 0; bus1.d_req = 0;
`ifdef ARB_FAIR_EN
        exp_seq = 4'b0101;  // D, I, D, I (bit 0 first)
`else
        exp_seq = 4'b0011;  // D, D, I, I
`endif
        chk("arb_count", 128'(ng), 128'(4));
        chk("arb_order", 128'(seq), 128'(exp_seq));
        for (int n = 1; n < 4; n++) begin
            if (n < ng) chk("arb_spacing", 128'(ncyc[n] - ncyc[n-1]), 128'(LAT + 3));
        end
        repeat (5) tick();

        // Reset during WAIT discards the read
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h10;
        neg();  chk("rstw_gnt", 128'(bus1.d_gnt), 128'(1));
        tick(); bus1.d_req = 0;
        tick(); rst = 1;
        tick(); rst = 0;
        neg();  chk("rstw_idle", {bus1.busy, bus1.mem_en, bus1.mem_we, bus1.mem_addr,
                    bus1.mem_wdata, bus1.d_rvalid}, 128'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            neg();
            chk("rstw_no_rvalid", {bus1.if_rvalid, bus1.d_rvalid}, 2'b00);
        end
        chk("rstw_rdata", 128'(bus1.d_rdata), 128'h0);
        tick(); bus1.if_req = 1; bus1.if_addr = 32'h10;
        neg();  chk("rstw_new_gnt", {bus1.if_gnt, bus1.d_gnt}, 2'b10);
        tick(); bus1.if_req = 0;
        tick(); tick();
        neg();  chk("rstw_new_data", {bus1.if_rvalid, bus1.if_rdata}, {1'b1, 32'hDEADBEEF});

        // MEM_LAT=3 instance: rvalid 5 cycles after gnt, busy in cycles 1..5
        tick(); bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 32'h10;
        neg();  chk("lat3_gnt", {bus3.busy, bus3.d_gnt}, 2'b01);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus3.d_req = 0;
            neg();
            chk("lat3_busy", 128'(bus3.busy), 128'(c <= 5));
            chk("lat3_rvalid", 128'(bus3.d_rvalid), 128'(c == 5));
            if (c == 5) chk("lat3_rdata", 128'(bus3.d_rdata), 128'h0DEADBEEF);
        end

        // Random traffic, checked by the model every cycle
        ig_prev = 0; dg_prev = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (bus1.if_req && ig_prev) begin
                bus1.if_req = ($urandom_range(0, 1) == 1);
                bus1.if_addr = 32'($urandom_range(0, 63));
            end else if (bus1.if_req) begin
                if ($urandom_range(0, 15) == 0) bus1.if_req = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus1.if_req = 1;
                bus1.if_addr = 32'($urandom_range(0, 63));
            end
            if (bus1.d_req && !dg_prev) begin
                if ($urandom_range(0, 15) == 0) bus1.d_req = 0;
            end else if (bus1.d_req || $urandom_range(0, 2) == 0) begin
                bus1.d_req = ($urandom_range(0, 3) != 0);
                bus1.d_we = $urandom_range(0, 1) == 1;
                bus1.d_addr = 32'($urandom_range(0, 63));
                bus1.d_wdata = $urandom;
            end
            neg();
            ig_prev = bus1.if_gnt;
            dg_prev = bus1.d_gnt;
        end
        tick(); bus1.if_req = 0; bus1.d_req = 0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the processor datapath. Each requester uses a req/gnt/rvalid handshake, and the arbiter serialises their accesses with one transaction outstanding at a time. It sits between the datapath stages and the unified memory; the control unit stalls the pipeline on a missing gnt/rvalid.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the memory access cycle to valid mem_rdata (legal 1..4)

- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with stable if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted (combinational, one cycle)
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  registered fetch data
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data accepted (combinational, one cycle)
- d_rvalid  out  1  one-cycle pulse: read data valid or write completed
- d_rdata  out  DATA_W  registered read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any request is pending, select the winner, pulse its gnt, latch owner/we/addr/wdata, then go to ACCESS. With no request, stay in IDLE.
- ACCESS (1 cycle): mem_en=1; mem_we=latched we; mem_addr/mem_wdata from latches. Go to WAIT with the counter loaded to MEM_LAT-1.
- WAIT (MEM_LAT cycles): on the cycle the counter reaches 0, capture mem_rdata into the owner's rdata register (reads only). Then go to RESP.
- RESP (1 cycle): owner's rvalid=1, then go to IDLE.
- Writes take the same path. d_rvalid pulses as a write acknowledge. d_rdata is not updated.
- Fetch is read-only and never writes.
- Arbitration, single requester: it wins immediately.
- Arbitration, both requesting: data wins by default. Fetch waits in IDLE until the next IDLE cycle.
- A requester dropping req before gnt is legal; no access occurs.
- Only one gnt is high in any cycle. No gnt is issued outside IDLE.
- Outside ACCESS: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- if_rdata/d_rdata hold their last captured value until the next capture.

## Timing
- Request present in IDLE at cycle T: gnt in T, mem_en in T+1, mem_rdata sampled at end of T+1+MEM_LAT, rvalid in T+MEM_LAT+2.
- Earliest next gnt is T+MEM_LAT+3. With MEM_LAT=1 this gives one access per 4 cycles.
- Reset values: state IDLE; all gnt/rvalid/mem_* outputs 0; busy 0; if_rdata=d_rdata=0; WAIT counter 0; round-robin pointer = fetch-last.
- Reset asserted in any state: IDLE on the next edge. The in-flight transaction is discarded and no rvalid is produced. A write already strobed in ACCESS is not undone.
- Request asserted during ACCESS/WAIT/RESP: it waits, and is evaluated in the next IDLE cycle.

## Configuration
- ARB_FAIR_EN defined: a pointer records the last granted requester. When both requesters are pending in IDLE, the one not granted last wins.
  - The pointer resets to fetch-last, so the first contention goes to data.
  - The pointer updates on every gnt.
- ARB_FAIR_EN undefined: fixed priority, data over fetch. No pointer register exists.

## Test plan
- Reset, then if_req with if_addr=0x10, MEM_LAT=1, memory holding 0xDEADBEEF at 0x10 -> if_gnt in cycle 0, mem_en in cycle 1, if_rvalid in cycle 3 with if_rdata=0xDEADBEEF.
- d_req write, d_addr=0x20, d_wdata=0x12345678 -> mem_we=1 in the access cycle. Then a d_req read of 0x20 -> d_rdata=0x12345678. d_rvalid pulses for both; d_rdata is unchanged after the write.
- if_req and d_req asserted together continuously, without ARB_FAIR_EN -> data granted first; fetch granted only after data drops req.
- Same stimulus with ARB_FAIR_EN -> grants alternate D, I, D, I, spaced MEM_LAT+3 cycles apart.
- MEM_LAT=3, d_req read -> d_rvalid exactly 5 cycles after d_gnt. busy high for cycles 1..5.
- Reset asserted during WAIT -> no rvalid ever. Next cycle: busy=0, all mem_* outputs 0. A new if_req is then granted normally.
